// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 sequencer: fetch/decode/execute FSM driving datapath control fields,
// with memory-wait handshake, watchdog bus-error halt and retired-instruction counter.
module legv8_multicycle_control #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] instruction_i,
   input  logic [4:0]  status_i,
   input  logic        mem_ready_i,
   output logic        ir_load_o,
   output logic        pc_inc_o,
   output logic        pc_load_o,
   output logic [3:0]  alu_op_o,
   output logic        alu_b_sel_o,
   output logic [4:0]  reg_a_o,
   output logic [4:0]  reg_b_o,
   output logic [4:0]  reg_w_o,
   output logic        reg_write_o,
   output logic        data_sel_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        addr_sel_o,
   output logic [1:0]  size_o,
   output logic [63:0] constant_o,
   output logic [2:0]  state_o,
   output logic        halt_o,
   output logic        bus_error_o,
   output logic [15:0] retired_o
);

   localparam int unsigned WD_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_LIMIT - 1);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ORR  = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b0111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
      OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ILL
   } op_e;

   state_e           state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [15:0]      retired_q, retired_d;
   logic             bus_error_q, bus_error_d;

   op_e              op;
   logic [4:0]       f_rd, f_rn, f_rm;
   logic             ir_load_s, pc_inc_s, pc_load_s, reg_write_s, mem_read_s, mem_write_s;
   logic             unused_status;

   assign f_rd = instruction_i[4:0];
   assign f_rn = instruction_i[9:5];
   assign f_rm = instruction_i[20:16];
   assign unused_status = ^status_i[4:1];

   always_comb begin
      op = OP_ILL;
      if (instruction_i[31:21] == 11'b10001011000)      op = OP_ADD;
      else if (instruction_i[31:21] == 11'b11001011000) op = OP_SUB;
      else if (instruction_i[31:21] == 11'b10001010000) op = OP_AND;
      else if (instruction_i[31:21] == 11'b10101010000) op = OP_ORR;
      else if (instruction_i[31:21] == 11'b11111000010) op = OP_LDUR;
      else if (instruction_i[31:21] == 11'b11111000000) op = OP_STUR;
      else if (instruction_i[31:22] == 10'b1001000100)  op = OP_ADDI;
      else if (instruction_i[31:22] == 10'b1101000100)  op = OP_SUBI;
      else if (instruction_i[31:24] == 8'b10110100)     op = OP_CBZ;
      else if (instruction_i[31:26] == 6'b000101)       op = OP_B;
   end

   always_comb begin
      constant_o = '0;
      unique case (op)
         OP_ADDI, OP_SUBI: constant_o = {52'b0, instruction_i[21:10]};
         OP_LDUR, OP_STUR: constant_o = {{55{instruction_i[20]}}, instruction_i[20:12]};
         OP_B:             constant_o = {{36{instruction_i[25]}}, instruction_i[25:0], 2'b00};
         OP_CBZ:           constant_o = {{43{instruction_i[23]}}, instruction_i[23:5], 2'b00};
         default:          constant_o = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      wd_d         = wd_q;
      bus_error_d  = bus_error_q;
      ir_load_s    = 1'b0;
      pc_inc_s     = 1'b0;
      pc_load_s    = 1'b0;
      reg_write_s  = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      alu_op_o     = ALU_AND;
      alu_b_sel_o  = 1'b0;
      reg_a_o      = '0;
      reg_b_o      = '0;
      reg_w_o      = '0;
      data_sel_o   = 1'b0;
      addr_sel_o   = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read_s = 1'b1;
            if (mem_ready_i) begin
               ir_load_s = 1'b1;
               state_d   = S_DECODE;
            end else if (wd_q == WD_LAST) begin
               bus_error_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_DECODE: begin
            if (op == OP_ILL)                          state_d = S_HALT;
            else if (op == OP_LDUR || op == OP_STUR)   state_d = S_MEM;
            else                                       state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            unique case (op)
               OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
                  reg_a_o     = f_rn;
                  reg_b_o     = f_rm;
                  reg_w_o     = f_rd;
                  alu_b_sel_o = (op == OP_ADDI || op == OP_SUBI);
                  reg_write_s = 1'b1;
                  pc_inc_s    = 1'b1;
                  unique case (op)
                     OP_ADD, OP_ADDI: alu_op_o = ALU_ADD;
                     OP_SUB, OP_SUBI: alu_op_o = ALU_SUB;
                     OP_ORR:          alu_op_o = ALU_ORR;
                     default:         alu_op_o = ALU_AND;
                  endcase
               end
               OP_B: pc_load_s = 1'b1;
               OP_CBZ: begin
                  // Branch decision uses the unregistered Z so the test and redirect share one cycle.
                  reg_b_o   = f_rd;
                  alu_op_o  = ALU_PASS;
                  pc_load_s = status_i[0];
                  pc_inc_s  = ~status_i[0];
               end
               default: ;
            endcase
         end
         S_MEM: begin
            reg_a_o     = f_rn;
            alu_b_sel_o = 1'b1;
            alu_op_o    = ALU_ADD;
            addr_sel_o  = 1'b1;
            if (op == OP_STUR) begin
               reg_b_o     = f_rd;
               mem_write_s = 1'b1;
            end else begin
               mem_read_s = 1'b1;
            end
            if (mem_ready_i) begin
               pc_inc_s = 1'b1;
               state_d  = S_FETCH;
               if (op != OP_STUR) begin
                  reg_write_s = 1'b1;
                  reg_w_o     = f_rd;
                  data_sel_o  = 1'b1;
               end
            end else if (wd_q == WD_LAST) begin
               bus_error_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase

      if (state_d != state_q) wd_d = '0;
   end

   assign retired_d = retired_q + {15'b0, pc_inc_s | pc_load_s};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_FETCH;
         wd_q        <= '0;
         retired_q   <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wd_q        <= wd_d;
         retired_q   <= retired_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Strobes are gated by reset directly so an access is abandoned the moment reset asserts.
   assign ir_load_o   = rst_ni & ir_load_s;
   assign pc_inc_o    = rst_ni & pc_inc_s;
   assign pc_load_o   = rst_ni & pc_load_s;
   assign reg_write_o = rst_ni & reg_write_s;
   assign mem_read_o  = rst_ni & mem_read_s;
   assign mem_write_o = rst_ni & mem_write_s;

   assign size_o      = 2'b11;
   assign state_o     = state_q;
   assign halt_o      = (state_q == S_HALT);
   assign bus_error_o = bus_error_q;
   assign retired_o   = retired_q;

endmodule
